pipeline_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline registers (F/D, D/E) and the PC enable. Generates:
//   - stall and flush controls;
//   - E-stage and D-stage forwarding selects;
//   - multi-cycle mult/div busy tracking;
//   - an instruction-memory wait state.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/forward_unit.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   pipe_state_t  : fetch wait-state FSM encoding (RUN / IWAIT)
//   FWD_*         : E-stage forwarding mux select codes
//   *_CYCLES_DEF  : default mult/div latencies, counted from issue in E
//   reg_hit()     : "producer writes a nonzero register equal to src"
package pipe_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        IWAIT = 1'b1
    } pipe_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int MULT_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF  = 32;

    // Register 0 is hardwired to zero, so a write to it never produces a hazard.
    function automatic logic reg_hit(input logic we, input logic [4:0] dst,
                                     input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding selects.
//   Inputs : RsD/RtD, RsE/RtE source registers; WriteRegM/W and RegWriteM/W
//            of the two producers that can still forward.
//   Outputs: ForwardAE/BE (FWD_RF/FWD_W/FWD_M, M wins over W),
//            ForwardAD/BD (M ALU result into the branch comparator).
module forward_unit
    import pipe_pkg::*;
(
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD
);

    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (reg_hit(RegWriteM, WriteRegM, RsE))      ForwardAE = FWD_M;
        else if (reg_hit(RegWriteW, WriteRegW, RsE)) ForwardAE = FWD_W;
        if (reg_hit(RegWriteM, WriteRegM, RtE))      ForwardBE = FWD_M;
        else if (reg_hit(RegWriteW, WriteRegW, RtE)) ForwardBE = FWD_W;
        ForwardAD = reg_hit(RegWriteM, WriteRegM, RsD);
        ForwardBD = reg_hit(RegWriteM, WriteRegM, RtD);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: drives PC enable, F/D EN/CLR and
// D/E CLR, forwarding selects, mult/div busy tracking and an imem wait state.
//   CLK, RST (sync, active-high)
//   RsD/RtD/RsE/RtE, WriteRegE/M/W, RegWriteE/M/W, MemtoRegE/M : hazard inputs
//   BranchD, PCSrcD : branch in D / taken
//   MDStartE, MDDivE, HiLoUseD : mult/div issue and HI/LO consumer in D
//   ImemReady : fetch data valid
//   EnPC, EnF, ClrF, ClrE, ForwardAE/BE/AD/BD, MDBusy : controls
//   state_dbg : current fetch FSM state, for observation only
// Handshake: ImemReady is a plain per-cycle valid from instruction memory;
// the fetch register only captures when EnF=1, and the cycle leaving IWAIT is
// also held so the late data lands in a held register.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 6
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  WriteRegE,
    input  logic [4:0]  WriteRegM,
    input  logic [4:0]  WriteRegW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        MemtoRegM,
    input  logic        BranchD,
    input  logic        PCSrcD,
    input  logic        MDStartE,
    input  logic        MDDivE,
    input  logic        HiLoUseD,
    input  logic        ImemReady,
    output logic        EnPC,
    output logic        EnF,
    output logic        ClrF,
    output logic        ClrE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic        MDBusy,
    output pipe_state_t state_dbg
);

    pipe_state_t      state, state_next;
    logic [CNT_W-1:0] mdcnt;
    logic             flush_pend;
    logic             md_busy;
    logic             lwstall, brstall, mdstall, istall, stall_d;
    logic [1:0]       fwd_ae, fwd_be;
    logic             fwd_ad, fwd_bd;

    forward_unit u_fwd (
        .RsD       (RsD),
        .RtD       (RtD),
        .RsE       (RsE),
        .RtE       (RtE),
        .WriteRegM (WriteRegM),
        .WriteRegW (WriteRegW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (fwd_ae),
        .ForwardBE (fwd_be),
        .ForwardAD (fwd_ad),
        .ForwardBD (fwd_bd)
    );

    assign md_busy = (mdcnt != '0);

    always_comb begin
        lwstall = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
        brstall = BranchD &&
                  (reg_hit(RegWriteE, WriteRegE, RsD) || reg_hit(RegWriteE, WriteRegE, RtD) ||
                   reg_hit(MemtoRegM, WriteRegM, RsD) || reg_hit(MemtoRegM, WriteRegM, RtD));
        // MDStartE counts too: the counter only becomes nonzero next cycle.
        mdstall = HiLoUseD && (md_busy || MDStartE);
        istall  = (state == IWAIT) || !ImemReady;
        // All sources OR into one hold, so coincident stalls give one bubble.
        stall_d = lwstall || brstall || mdstall || istall;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (!ImemReady) state_next = IWAIT;
            IWAIT:   if (ImemReady)  state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        EnPC      = 1'b0;
        EnF       = 1'b0;
        ClrF      = 1'b1;
        ClrE      = 1'b1;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        MDBusy    = 1'b0;
        if (!RST) begin
            EnPC      = !stall_d;
            EnF       = !stall_d;
            // Fetch register gives CLR priority over EN, so a flush must wait
            // until D is released; flush_pend carries it across the stall.
            ClrF      = (PCSrcD || flush_pend) && !stall_d;
            ClrE      = stall_d;
            ForwardAE = fwd_ae;
            ForwardBE = fwd_be;
            ForwardAD = fwd_ad;
            ForwardBD = fwd_bd;
            MDBusy    = md_busy;
        end
    end

    assign state_dbg = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= RUN;
            mdcnt      <= '0;
            flush_pend <= 1'b0;
        end else begin
            state <= state_next;
            // A start while already busy is ignored.
            if (MDStartE && !md_busy)
                mdcnt <= MDDivE ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            else if (md_busy)
                mdcnt <= mdcnt - CNT_W'(1);
            if (PCSrcD && stall_d)
                flush_pend <= 1'b1;
            else if (!stall_d)
                flush_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
    import pipe_pkg::*;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic        BranchD, PCSrcD, MDStartE, MDDivE, HiLoUseD, ImemReady;
    logic        EnPC, EnF, ClrF, ClrE, ForwardAD, ForwardBD, MDBusy;
    logic [1:0]  ForwardAE, ForwardBE;
    pipe_state_t state_dbg;

    pipeline_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
        .CLK(CLK), .RST(RST),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .PCSrcD(PCSrcD),
        .MDStartE(MDStartE), .MDDivE(MDDivE), .HiLoUseD(HiLoUseD),
        .ImemReady(ImemReady),
        .EnPC(EnPC), .EnF(EnF), .ClrF(ClrF), .ClrE(ClrE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .MDBusy(MDBusy), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time-based view: cycle number, the cycle at which the mult/div result is
    // ready, whether fetch data was valid last cycle, and an owed flush.
    int cyc        = 0;
    int md_end     = 0;
    bit prev_ready = 1'b1;
    bit flush_owed = 1'b0;
    bit m_stall;

    function automatic bit uses(input bit we, input logic [4:0] dst, input logic [4:0] src);
        return we && dst != 0 && dst == src;
    endfunction

    function automatic int fwd_e(input logic [4:0] src);
        if (uses(RegWriteM, WriteRegM, src)) return 2;
        if (uses(RegWriteW, WriteRegW, src)) return 1;
        return 0;
    endfunction

    // ---------------- driver ----------------
    task automatic idle_inputs();
        RST = 0; RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
        BranchD = 0; PCSrcD = 0; MDStartE = 0; MDDivE = 0; HiLoUseD = 0; ImemReady = 1;
    endtask

    task automatic random_inputs();
        RST       = ($urandom_range(0, 99) == 0);
        RsD       = 5'($urandom_range(0, 3));
        RtD       = 5'($urandom_range(0, 3));
        RsE       = 5'($urandom_range(0, 3));
        RtE       = 5'($urandom_range(0, 3));
        WriteRegE = 5'($urandom_range(0, 3));
        WriteRegM = 5'($urandom_range(0, 3));
        WriteRegW = 5'($urandom_range(0, 3));
        RegWriteE = 1'($urandom);
        RegWriteM = 1'($urandom);
        RegWriteW = 1'($urandom);
        MemtoRegE = ($urandom_range(0, 3) == 0);
        MemtoRegM = ($urandom_range(0, 3) == 0);
        BranchD   = ($urandom_range(0, 3) == 0);
        PCSrcD    = ($urandom_range(0, 5) == 0);
        MDStartE  = ($urandom_range(0, 15) == 0);
        MDDivE    = ($urandom_range(0, 3) == 0);
        HiLoUseD  = ($urandom_range(0, 3) == 0);
        ImemReady = ($urandom_range(0, 4) != 0);
    endtask

    // Check all outputs mid-cycle against the model, then advance one clock.
    task automatic step();
        bit busy, lw, br, md, is;
        @(negedge CLK);
        busy = cyc < md_end;
        lw = MemtoRegE && (RtE == RsD || RtE == RtD);
        br = BranchD && (uses(RegWriteE, WriteRegE, RsD) || uses(RegWriteE, WriteRegE, RtD) ||
                         uses(MemtoRegM, WriteRegM, RsD) || uses(MemtoRegM, WriteRegM, RtD));
        md = HiLoUseD && (busy || MDStartE);
        is = !ImemReady || !prev_ready;
        m_stall = lw || br || md || is;
        if (RST) begin
            check_eq("rst_enpc", EnPC, 0);
            check_eq("rst_enf", EnF, 0);
            check_eq("rst_clrf", ClrF, 1);
            check_eq("rst_clre", ClrE, 1);
            check_eq("rst_fwd", {ForwardAE, ForwardBE, ForwardAD, ForwardBD}, 0);
            check_eq("rst_mdbusy", MDBusy, 0);
        end else begin
            check_eq("enpc", EnPC, !m_stall);
            check_eq("enf", EnF, !m_stall);
            check_eq("clrf", ClrF, (PCSrcD || flush_owed) && !m_stall);
            check_eq("clre", ClrE, m_stall);
            check_eq("fwd_ae", ForwardAE, fwd_e(RsE));
            check_eq("fwd_be", ForwardBE, fwd_e(RtE));
            check_eq("fwd_ad", ForwardAD, uses(RegWriteM, WriteRegM, RsD));
            check_eq("fwd_bd", ForwardBD, uses(RegWriteM, WriteRegM, RtD));
            check_eq("mdbusy", MDBusy, busy);
            check_eq("state", state_dbg, !prev_ready);
        end
        @(posedge CLK);
        if (RST) begin
            md_end = 0; prev_ready = 1'b1; flush_owed = 1'b0;
        end else begin
            if (MDStartE && !busy) md_end = cyc + (MDDivE ? DIV_N : MULT_N);
            prev_ready = ImemReady;
            if (PCSrcD && m_stall) flush_owed = 1'b1;
            else if (!m_stall)     flush_owed = 1'b0;
        end
        cyc++;
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        idle_inputs();
        RST = 1;
        step(); step();
        RST = 0;
        step();

        // load-use: one bubble, then W forwarding
        MemtoRegE = 1; RtE = 8; RsD = 8; #1;
        check_eq("lw_enf", EnF, 0);
        check_eq("lw_clre", ClrE, 1);
        step();
        MemtoRegE = 0; RtE = 0; RsD = 0; RsE = 8; RegWriteW = 1; WriteRegW = 8; #1;
        check_eq("lw_fwd_w", ForwardAE, 2'b01);
        step();

        // M over W priority, register 0 never forwarded
        RegWriteM = 1; WriteRegM = 9; RsE = 9; RegWriteW = 0; #1;
        check_eq("fwd_m", ForwardAE, 2'b10);
        step();
        RegWriteW = 1; WriteRegW = 9; #1;
        check_eq("fwd_m_prio", ForwardAE, 2'b10);
        step();
        WriteRegM = 0; RsE = 0; WriteRegW = 0; #1;
        check_eq("fwd_r0", ForwardAE, 2'b00);
        step();
        idle_inputs();

        // divide: MDBusy high exactly DIV_N-1 cycles, mflo held meanwhile
        MDStartE = 1; MDDivE = 1; HiLoUseD = 1;
        step();
        MDStartE = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (MDBusy) n++;
            step();
        end
        check_eq("div_busy_len", n, DIV_N - 1);
        check_eq("div_release_clre", ClrE, 0);
        idle_inputs();

        // imem not ready 3 cycles -> 4 held cycles, no flush
        n = 0;
        for (int i = 0; i < 7; i++) begin
            ImemReady = (i < 3) ? 1'b0 : 1'b1; #1;
            if (!EnF) n++;
            step();
        end
        check_eq("iwait_hold_len", n, 4);

        // taken branch during fetch wait: deferred flush
        PCSrcD = 1; ImemReady = 0;
        step();
        PCSrcD = 0;
        step();
        ImemReady = 1;
        step();
        #1;
        check_eq("defer_clrf", ClrF, 1);
        step();
        #1;
        check_eq("defer_cleared", ClrF, 0);

        // reset mid-divide
        MDStartE = 1; MDDivE = 1;
        step();
        MDStartE = 0;
        repeat (10) step();
        RST = 1;
        step();
        RST = 0; #1;
        check_eq("rst_mid_div_busy", MDBusy, 0);
        check_eq("rst_mid_div_state", state_dbg, RUN);
        step();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
